serial_add_seq: RTL and testbench
=================================

# serial_add_seq

Bit-serial adder sequencer sitting directly in front of the 1-bit full adder (`adder`: a, b, cin -> sum, cout). It accepts two WIDTH-bit operands, presents them LSB-first to the full adder one bit per clock, and registers the carry between bits. It collects the sum bits into a WIDTH-bit result plus final carry. A start/busy/done handshake lets a controller run multi-bit additions through the single-bit datapath.

## Interface

- WIDTH, 8, operand and result width in bits; legal range is WIDTH ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse/level, sampled on the rising edge.
- op_a  input  WIDTH  operand A, sampled when start is accepted.
- op_b  input  WIDTH  operand B, sampled when start is accepted.
- cin_init  input  1  carry-in for bit 0, sampled when start is accepted.
- busy  output  1  high while bits are being shifted.
- done  output  1  one-cycle pulse when result/carry_out are updated.
- result  output  WIDTH  final sum; holds until the next completion.
- carry_out  output  1  final carry; holds until the next completion.
- add_a  output  1  to adder a.
- add_b  output  1  to adder b.
- add_cin  output  1  to adder cin.
- add_sum  input  1  from adder sum.
- add_cout  input  1  from adder cout.

## Operation

- States: IDLE, SHIFT, DONE.
- The block accepts start only in IDLE or DONE. An accepted start does the following:
  - Loads sh_a<=op_a and sh_b<=op_b.
  - Loads carry<=cin_init.
  - Clears the bit counter cnt (width ceil(log2(WIDTH+1))).
  - Clears the accumulator acc.
  - Moves the state to SHIFT.
- The block ignores start while in SHIFT. Operands, state and outputs are unaffected.
- In SHIFT, the adder drives are combinational from registers:
  - add_a=sh_a[0]
  - add_b=sh_b[0]
  - add_cin=carry
- On each SHIFT edge:
  - acc<={add_sum, acc[WIDTH-1:1]} (shift right, sum enters at the MSB).
  - carry<=add_cout.
  - sh_a and sh_b shift right, with 0 filled in.
  - cnt<=cnt+1.
- On the edge where cnt==WIDTH-1 (the WIDTH-th shift):
  - result<={add_sum, acc[WIDTH-1:1]}.
  - carry_out<=add_cout.
  - Next state is DONE.
- DONE lasts exactly one cycle, then the state returns to IDLE. If start is sampled high in DONE, the next state is SHIFT instead.
- Outside SHIFT, add_a, add_b and add_cin are all 0.
- busy = (state==SHIFT). done = (state==DONE).
- Arithmetic: {carry_out,result} = op_a + op_b + cin_init, exactly, modulo 2^(WIDTH+1). No overflow flag.
- Reset values (asynchronous):
  - state=IDLE.
  - busy=0, done=0.
  - result=0, carry_out=0.
  - add_a=0, add_b=0, add_cin=0.
  - All internal registers=0.
- Reset mid-operation aborts the addition immediately. result and carry_out return to 0 and no done is produced. After rst_n deasserts, the first accepted start begins a fresh operation.

## Timing

- Start accepted at edge k. busy is high after edges k .. k+WIDTH-1, which is exactly WIDTH cycles.
- done is high for the single cycle following edge k+WIDTH. result and carry_out are valid from that same cycle.
- Latency from start edge to done is WIDTH+1 edges. Operation-to-operation throughput is WIDTH+1 cycles when start is held high.
- Bit i of the operands is on add_a/add_b during the cycle after edge k+i.
- The adder is purely combinational. add_sum and add_cout must settle within the same cycle. There are no pipeline registers in the adder path.
- WIDTH=1: busy is high for 1 cycle and done follows on the next cycle.

## Test plan

- Reset, then hold start=0 for 5 cycles -> all outputs 0, busy and done never asserted.
- WIDTH=8, op_a=8'h3C, op_b=8'h42, cin_init=0 -> done after 9 edges, result=8'h7E, carry_out=0. busy is high for exactly 8 cycles. add_a sequence LSB-first is 0,0,1,1,1,1,0,0.
- op_a=8'hFF, op_b=8'h01, cin_init=0 -> result=8'h00, carry_out=1.
- op_a=8'hA5, op_b=8'h5A, cin_init=1 -> result=8'h00, carry_out=1.
- Start held high continuously with op 8'h10+8'h20, then start pulsed in mid-SHIFT with different operands:
  - Mid-SHIFT pulse is ignored; first result=8'h30.
  - Back-to-back accept in the DONE cycle yields the second done exactly 9 cycles after the first.
  - result holds 8'h30 until the second completion.
- rst_n asserted low on the 4th SHIFT cycle of 8'hFF+8'hFF:
  - busy, done, result and carry_out go to 0 immediately (asynchronous) and no done pulse is produced.
  - A subsequent 8'hFF+8'hFF+1 gives result=8'hFF, carry_out=1.

Source files
------------

// File: rtl/serial_add_seq_if.sv
// ----------------------------------------------------------------------------
// serial_add_seq_if
// Bundles the signals of the bit-serial adder sequencer.
//   Controller side : start, op_a, op_b, cin_init  -> sequencer
//                     busy, done, result, carry_out <- sequencer
//   Adder side      : add_a, add_b, add_cin         -> 1-bit full adder
//                     add_sum, add_cout             <- 1-bit full adder
// Modports:
//   slave  - the sequencer itself
//   master - the controller issuing additions
//   adder  - the external combinational full adder
// ----------------------------------------------------------------------------
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin_init;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             add_a;
    logic             add_b;
    logic             add_cin;
    logic             add_sum;
    logic             add_cout;

    modport slave (
        input  start, op_a, op_b, cin_init, add_sum, add_cout,
        output busy, done, result, carry_out, add_a, add_b, add_cin
    );

    modport master (
        output start, op_a, op_b, cin_init,
        input  busy, done, result, carry_out
    );

    modport adder (
        input  add_a, add_b, add_cin,
        output add_sum, add_cout
    );
endinterface

// File: rtl/serial_add_seq.sv
// ----------------------------------------------------------------------------
// serial_add_seq
// Runs WIDTH-bit additions through an external 1-bit full adder, one bit per
// clock, LSB first. The carry between bits is held in a register here; the
// full adder itself is purely combinational and lives outside this block.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - serial_add_seq_if.slave:
//              start/op_a/op_b/cin_init  sampled when start is accepted
//              busy                      high while bits are shifted
//              done                      one-cycle completion pulse
//              result/carry_out          final sum, held until next done
//              add_a/add_b/add_cin       drives to the full adder
//              add_sum/add_cout          returned from the full adder
// ----------------------------------------------------------------------------
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_seq_if.slave    bus
);

    localparam int                 CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;

    logic               w_accept;
    logic               w_in_shift;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_next;

    // Start is only honoured outside SHIFT; DONE may accept so that a held
    // start gives WIDTH+1 cycle throughput.
    assign w_in_shift = (r_state == S_SHIFT);
    assign w_accept   = bus.start && !w_in_shift;
    assign w_last     = w_in_shift && (r_cnt == LAST_CNT);

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 of the
    // sum has travelled down to bit 0 of the accumulator.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign w_acc_next = bus.add_sum;
        end else begin : g_acc_wn
            assign w_acc_next = {bus.add_sum, r_acc[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == LAST_CNT) w_state_next = S_DONE;
            S_DONE:  w_state_next = bus.start ? S_SHIFT : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Adder drives are forced low outside SHIFT so the
    // adder sees a quiet 0+0+0 when no addition is running.
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy    = w_in_shift;
        bus.done    = (r_state == S_DONE);
        bus.add_a   = 1'b0;
        bus.add_b   = 1'b0;
        bus.add_cin = 1'b0;
        if (w_in_shift) begin
            bus.add_a   = r_sh_a[0];
            bus.add_b   = r_sh_b[0];
            bus.add_cin = r_carry;
        end
    end

    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_sh_a  <= bus.op_a;
            r_sh_b  <= bus.op_b;
            r_carry <= bus.cin_init;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (w_in_shift) begin
            r_sh_a  <= r_sh_a >> 1;
            r_sh_b  <= r_sh_b >> 1;
            r_carry <= bus.add_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_acc   <= w_acc_next;
            if (w_last) begin
                r_result    <= w_acc_next;
                r_carry_out <= bus.add_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// ----------------------------------------------------------------------------
// tb_serial_add_seq
// Drives serial_add_seq with directed and random additions. The external full
// adder is modelled by continuous assignments; expected sums come from plain
// integer addition of the operands.
// ----------------------------------------------------------------------------
module tb_serial_add_seq;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    serial_add_seq_if #(.WIDTH(W)) bus ();

    serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Purely combinational 1-bit full adder in front of the sequencer.
    assign bus.add_sum  = bus.add_a ^ bus.add_b ^ bus.add_cin;
    assign bus.add_cout = (bus.add_a & bus.add_b) | (bus.add_cin & (bus.add_a ^ bus.add_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full addition: accept, check every SHIFT cycle, check completion.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] exp_sum;
        int         carry_in_i;
        int         mask;
        exp_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.cin_init = cin;
        @(posedge clk); #1;
        bus.start = 1'b0;
        // Operands must have been captured; scramble the inputs.
        bus.op_a     = W'($urandom);
        bus.op_b     = W'($urandom);
        bus.cin_init = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            mask       = (1 << i) - 1;
            carry_in_i = ((int'(a) & mask) + (int'(b) & mask) + int'(cin)) >> i;
            check_eq("busy", 32'(bus.busy), 32'd1);
            check_eq("done_early", 32'(bus.done), 32'd0);
            check_eq("add_a", 32'(bus.add_a), 32'(a[i]));
            check_eq("add_b", 32'(bus.add_b), 32'(b[i]));
            check_eq("add_cin", 32'(bus.add_cin), 32'(carry_in_i & 1));
            @(posedge clk); #1;
        end
        check_eq("done", 32'(bus.done), 32'd1);
        check_eq("busy_off", 32'(bus.busy), 32'd0);
        check_eq("result", 32'(bus.result), 32'(exp_sum[W-1:0]));
        check_eq("carry_out", 32'(bus.carry_out), 32'(exp_sum[W]));
        check_eq("add_idle", 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
        $display("op %02h + %02h + %0d -> result %02h carry %0d", a, b, cin, bus.result, bus.carry_out);
        @(posedge clk); #1;
        check_eq("done_pulse", 32'(bus.done), 32'd0);
        check_eq("result_hold", 32'(bus.result), 32'(exp_sum[W-1:0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap;
        n_cmp = 0;
        n_err = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.cin_init = 1'b0;

        // Reset and idle: all outputs quiet.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("idle_outs",
                     32'({bus.busy, bus.done, bus.result, bus.carry_out, bus.add_a, bus.add_b, bus.add_cin}),
                     32'd0);
        end

        // Directed cases.
        do_op(8'h3C, 8'h42, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'hA5, 8'h5A, 1'b1);

        // Start held high; mid-SHIFT operand change ignored; back-to-back in DONE.
        begin
            int cyc;
            @(negedge clk);
            bus.start    = 1'b1;
            bus.op_a     = 8'h10;
            bus.op_b     = 8'h20;
            bus.cin_init = 1'b0;
            @(posedge clk); #1;
            repeat (3) begin
                @(posedge clk); #1;
            end
            bus.op_a = 8'h55;
            bus.op_b = 8'h0F;
            cyc = 0;
            while (!bus.done && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            check_eq("b2b_first_done", 32'(bus.done), 32'd1);
            check_eq("b2b_first_result", 32'(bus.result), 32'h30);
            check_eq("b2b_first_carry", 32'(bus.carry_out), 32'd0);
            $display("held start: first result %02h", bus.result);
            @(posedge clk); #1;
            bus.start = 1'b0;
            check_eq("b2b_reaccept", 32'(bus.busy), 32'd1);
            cyc = 1;
            while (!bus.done && cyc < 20) begin
                check_eq("b2b_hold", 32'(bus.result), 32'h30);
                @(posedge clk); #1;
                cyc++;
            end
            check_eq("b2b_spacing", 32'(cyc), 32'd9);
            check_eq("b2b_second_result", 32'(bus.result), 32'h64);
            check_eq("b2b_second_carry", 32'(bus.carry_out), 32'd0);
            $display("held start: second result %02h after %0d cycles", bus.result, cyc);
        end

        // Asynchronous reset in the 4th SHIFT cycle.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op_a     = 8'hFF;
        bus.op_b     = 8'hFF;
        bus.cin_init = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_outs",
                 32'({bus.busy, bus.done, bus.result, bus.carry_out, bus.add_a, bus.add_b, bus.add_cin}),
                 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check_eq("post_rst_quiet", 32'({bus.busy, bus.done}), 32'd0);
        end
        $display("reset mid-op: outputs cleared, no done");
        do_op(8'hFF, 8'hFF, 1'b1);

        // Random additions with random idle gaps.
        for (int t = 0; t < 30; t++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(posedge clk);
            do_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
